// File: rtl/s_mem_scheduler.sv
// Runs the RC4 engines in index order and arbitrates the single port of the shared S memory.
// Only the engine that currently holds the grant can reach the memory; reads are tagged with their owner.
module s_mem_scheduler #(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned N_ENG    = 3,
   parameter int unsigned READ_LAT = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic                      err,
   output logic [N_ENG-1:0]          eng_start,
   input  logic [N_ENG-1:0]          eng_done,
   output logic [N_ENG-1:0]          eng_gnt,
   input  logic [N_ENG-1:0]          eng_req,
   input  logic [N_ENG-1:0]          eng_wren,
   input  logic [N_ENG*ADDR_W-1:0]   eng_addr,
   input  logic [N_ENG*DATA_W-1:0]   eng_wdata,
   output logic [DATA_W-1:0]         eng_rdata,
   output logic [N_ENG-1:0]          eng_rvalid,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_data,
   output logic                      mem_wren,
   input  logic [DATA_W-1:0]         mem_q
);

   localparam int unsigned PH_W = (N_ENG > 1) ? $clog2(N_ENG) : 1;

   typedef enum logic [2:0] {StIdle, StStart, StRun, StDrain, StDone} state_e;

   state_e              state;
   logic [PH_W-1:0]     ph;
   logic [READ_LAT-1:0] rd_vld;
   logic [PH_W-1:0]     rd_own [READ_LAT];

   logic                rd_issue;
   logic [PH_W-1:0]     rd_issue_own;
   logic                bad_req;

   // Only the granted engine reaches the memory; rst blocks any access in its own cycle.
   always_comb begin
      mem_addr     = '0;
      mem_data     = '0;
      mem_wren     = 1'b0;
      rd_issue     = 1'b0;
      rd_issue_own = '0;
      for (int k = 0; k < N_ENG; k++) begin
         if (!rst && eng_gnt[k] && eng_req[k]) begin
            mem_addr     = eng_addr[k*ADDR_W +: ADDR_W];
            mem_data     = eng_wdata[k*DATA_W +: DATA_W];
            mem_wren     = eng_wren[k];
            rd_issue     = !eng_wren[k];
            rd_issue_own = PH_W'(k);
         end
      end
      bad_req = |(eng_req & ~eng_gnt);
   end

   always_comb begin
      eng_rdata = mem_q;
      for (int k = 0; k < N_ENG; k++) begin
         eng_rvalid[k] = rd_vld[READ_LAT-1] && (rd_own[READ_LAT-1] == PH_W'(k));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_vld <= '0;
         for (int i = 0; i < READ_LAT; i++) rd_own[i] <= '0;
      end else begin
         rd_vld[0] <= rd_issue;
         rd_own[0] <= rd_issue_own;
         for (int i = 1; i < READ_LAT; i++) begin
            rd_vld[i] <= rd_vld[i-1];
            rd_own[i] <= rd_own[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= StIdle;
         ph        <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         eng_start <= '0;
         eng_gnt   <= '0;
      end else begin
         eng_start <= '0;
         err       <= err | bad_req;
         unique case (state)
            StIdle, StDone: begin
               if (start) begin
                  state     <= StStart;
                  ph        <= '0;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  err       <= bad_req;
                  eng_start <= N_ENG'(1);
               end
            end
            StStart: begin
               state   <= StRun;
               eng_gnt <= N_ENG'(1) << ph;
            end
            StRun: begin
               if (eng_done[ph]) begin
                  state   <= StDrain;
                  eng_gnt <= '0;
               end
            end
            StDrain: begin
               // The next engine starts only once every read of the current owner has returned.
               if (rd_vld == '0) begin
                  if (ph == PH_W'(N_ENG - 1)) begin
                     state <= StDone;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state     <= StStart;
                     ph        <= ph + PH_W'(1);
                     eng_start <= N_ENG'(1) << (ph + PH_W'(1));
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule
